lane_reorder_ctrl: RTL and testbench

//  Sequences lane reordering in the 100GbE PCS RX path, after AM lock and deskew and ahead of the reorder mux.

---
 rtl/pcs_lane_pkg.sv | 41 ++++
 rtl/lane_id_checker.sv | 24 ++
 rtl/lane_reorder_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lane_reorder_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_lane_pkg.sv
// Shared lane-reorder definitions: lane count, ID field width, FSM states and
// helpers to read/write one NB_ID field of a packed per-lane bus.
package pcs_lane_pkg;

  localparam int N_LANES   = 20;
  localparam int NB_ID     = $clog2(N_LANES);
  localparam int NB_ID_BUS = N_LANES * NB_ID;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_WAIT_DESKEW = 3'd2,
    ST_BUILD       = 3'd3,
    ST_CHECK       = 3'd4,
    ST_LOCKED      = 3'd5,
    ST_ERROR       = 3'd6
  } state_e;

  // Lane 0 sits in the most significant field; indices >= N_LANES read as 0.
  function automatic logic [NB_ID-1:0] get_field(input logic [NB_ID_BUS-1:0] bus,
                                                 input logic [NB_ID-1:0]     idx);
    logic [NB_ID-1:0] r;
    r = '0;
    for (int l = 0; l < N_LANES; l++) begin
      if (idx == NB_ID'(l)) r = bus[NB_ID_BUS-1-l*NB_ID -: NB_ID];
    end
    return r;
  endfunction

  function automatic logic [NB_ID_BUS-1:0] put_field(input logic [NB_ID_BUS-1:0] bus,
                                                     input logic [NB_ID-1:0]     idx,
                                                     input logic [NB_ID-1:0]     val);
    logic [NB_ID_BUS-1:0] r;
    r = bus;
    for (int l = 0; l < N_LANES; l++) begin
      if (idx == NB_ID'(l)) r[NB_ID_BUS-1-l*NB_ID -: NB_ID] = val;
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_id_checker.sv
// Classifies one received lane ID against the bitmap of IDs already claimed:
// out of range, duplicate, and the bitmap with this ID added.
module lane_id_checker
  import pcs_lane_pkg::*;
(
  input  logic [NB_ID-1:0]   i_id,
  input  logic [N_LANES-1:0] i_seen,
  output logic               o_range_err,
  output logic               o_dup_err,
  output logic [N_LANES-1:0] o_seen_next
);

  logic [N_LANES-1:0] id_hot;

  // One-hot decode; an out-of-range ID decodes to all zeros.
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_hot
    assign id_hot[gi] = (i_id == NB_ID'(gi));
  end

  assign o_range_err = ~|id_hot;
  assign o_dup_err   = |(id_hot & i_seen);
  assign o_seen_next = i_seen | id_hot;

endmodule

// File: rtl/lane_reorder_ctrl.sv
// 100GbE PCS RX lane reorder sequencer: waits for AM lock and deskew, walks the
// per-lane IDs into the reorder mux selector, validates it, and supervises lock.
module lane_reorder_ctrl
  import pcs_lane_pkg::*;
#(
  parameter int                    NB_TIMEOUT = 16,
  parameter logic [NB_TIMEOUT-1:0] DESKEW_TMO = 16'd4096
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [N_LANES-1:0]   i_align_lock,
  input  logic                 i_deskew_done,
  input  logic [NB_ID_BUS-1:0] i_ID,
  output logic [NB_ID_BUS-1:0] o_reorder_mux_selector,
  output logic                 o_reorder_valid,
  output logic                 o_resync_req,
  output logic                 o_err_dup,
  output logic                 o_err_range,
  output logic [2:0]           o_state
);

  state_e                state_q, state_d;
  logic [NB_ID-1:0]      lane_cnt_q, lane_cnt_d;
  logic [NB_TIMEOUT-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [N_LANES-1:0]    seen_q, seen_d;
  logic [NB_ID_BUS-1:0]  sel_q, sel_d;
  logic                  err_dup_q, err_dup_d;
  logic                  err_range_q, err_range_d;
  logic                  valid_q, valid_d;
  logic                  resync_q, resync_d;
  logic                  deskew_prev_q, deskew_prev_d;

  logic                  all_lock;
  logic [NB_ID-1:0]      cur_id;
  logic                  chk_range, chk_dup;
  logic [N_LANES-1:0]    chk_seen_next;

  assign all_lock = &i_align_lock;
  assign cur_id   = get_field(i_ID, lane_cnt_q);

  lane_id_checker u_id_chk (
    .i_id        (cur_id),
    .i_seen      (seen_q),
    .o_range_err (chk_range),
    .o_dup_err   (chk_dup),
    .o_seen_next (chk_seen_next)
  );

  always_comb begin
    state_d       = state_q;
    lane_cnt_d    = lane_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    seen_d        = seen_q;
    sel_d         = sel_q;
    err_dup_d     = err_dup_q;
    err_range_d   = err_range_q;
    valid_d       = valid_q;
    resync_d      = resync_q;
    deskew_prev_d = deskew_prev_q;

    if (i_enable) begin
      deskew_prev_d = i_deskew_done;
      // Valid trails the LOCKED state by one registered stage.
      valid_d       = (state_q == ST_LOCKED);
      resync_d      = 1'b0;

      case (state_q)
        ST_IDLE: state_d = ST_WAIT_LOCK;

        ST_WAIT_LOCK: begin
          if (all_lock) begin
            state_d   = ST_WAIT_DESKEW;
            tmo_cnt_d = '0;
          end
        end

        ST_WAIT_DESKEW: begin
          if (!all_lock) begin
            state_d = ST_WAIT_LOCK;
          end else if (i_deskew_done) begin
            state_d     = ST_BUILD;
            lane_cnt_d  = '0;
            seen_d      = '0;
            sel_d       = '0;
            err_dup_d   = 1'b0;
            err_range_d = 1'b0;
          end else if (i_valid) begin
            if (tmo_cnt_q == DESKEW_TMO - NB_TIMEOUT'(1)) begin
              state_d  = ST_ERROR;
              resync_d = 1'b1;
            end else begin
              tmo_cnt_d = tmo_cnt_q + NB_TIMEOUT'(1);
            end
          end
        end

        ST_BUILD: begin
          // A lock drop pre-empts the walk step, including the final one.
          if (!all_lock) begin
            state_d = ST_WAIT_LOCK;
          end else if (i_valid) begin
            if (chk_range) begin
              err_range_d = 1'b1;
            end else if (chk_dup) begin
              err_dup_d = 1'b1;
            end else begin
              sel_d  = put_field(sel_q, cur_id, lane_cnt_q);
              seen_d = chk_seen_next;
            end
            lane_cnt_d = lane_cnt_q + NB_ID'(1);
            if (lane_cnt_q == NB_ID'(N_LANES - 1)) state_d = ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (err_dup_q || err_range_q || !(&seen_q)) begin
            state_d  = ST_ERROR;
            resync_d = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end

        ST_LOCKED: begin
          if (!all_lock || (deskew_prev_q && !i_deskew_done)) state_d = ST_WAIT_LOCK;
        end

        ST_ERROR: state_d = ST_WAIT_LOCK;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      lane_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      seen_q        <= '0;
      sel_q         <= '0;
      err_dup_q     <= 1'b0;
      err_range_q   <= 1'b0;
      valid_q       <= 1'b0;
      resync_q      <= 1'b0;
      deskew_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      seen_q        <= seen_d;
      sel_q         <= sel_d;
      err_dup_q     <= err_dup_d;
      err_range_q   <= err_range_d;
      valid_q       <= valid_d;
      resync_q      <= resync_d;
      deskew_prev_q <= deskew_prev_d;
    end
  end

  assign o_reorder_mux_selector = sel_q;
  assign o_reorder_valid        = valid_q;
  assign o_resync_req           = resync_q;
  assign o_err_dup              = err_dup_q;
  assign o_err_range            = err_range_q;
  assign o_state                = state_q;

endmodule

// File: tb/tb_lane_reorder_ctrl.sv
// Self-checking bench for lane_reorder_ctrl: table of ID maps with expected
// selectors/flags through a scoreboard queue, plus multi-cycle corner sequences.
module tb_lane_reorder_ctrl;
  import pcs_lane_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic                 vld;
  logic [N_LANES-1:0]   lock;
  logic                 deskew;
  logic [NB_ID_BUS-1:0] ids;
  logic [NB_ID_BUS-1:0] o_sel;
  logic                 o_valid, o_resync, o_dup, o_rng;
  logic [2:0]           o_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string                name;
    logic [NB_ID_BUS-1:0] ids;
    bit                   ok;
    logic [NB_ID_BUS-1:0] sel;
    bit                   dup;
    bit                   rng;
  } vec_t;

  vec_t vecs[6];
  vec_t exp_q[$];

  lane_reorder_ctrl #(.NB_TIMEOUT(16), .DESKEW_TMO(16'd64)) dut (
    .i_clock                (clk),
    .i_reset_n              (rst_n),
    .i_enable               (en),
    .i_valid                (vld),
    .i_align_lock           (lock),
    .i_deskew_done          (deskew),
    .i_ID                   (ids),
    .o_reorder_mux_selector (o_sel),
    .o_reorder_valid        (o_valid),
    .o_resync_req           (o_resync),
    .o_err_dup              (o_dup),
    .o_err_range            (o_rng),
    .o_state                (o_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_sel(input string nm, input logic [NB_ID_BUS-1:0] act,
                         input logic [NB_ID_BUS-1:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  function automatic logic [NB_ID_BUS-1:0] putf(input logic [NB_ID_BUS-1:0] b,
                                                input int idx, input int v);
    b[NB_ID_BUS-1-idx*NB_ID -: NB_ID] = NB_ID'(v);
    return b;
  endfunction

  task automatic make_perm(output vec_t v, input string nm);
    int perm[N_LANES];
    int j;
    int t;
    for (int i = 0; i < N_LANES; i++) perm[i] = i;
    for (int i = N_LANES - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    v.name = nm; v.ok = 1'b1; v.dup = 1'b0; v.rng = 1'b0; v.ids = '0; v.sel = '0;
    for (int p = 0; p < N_LANES; p++) begin
      v.ids = putf(v.ids, p, perm[p]);
      v.sel = putf(v.sel, perm[p], p);
    end
  endtask

  // Waits for either valid or a resync pulse, counting edges; bounded.
  task automatic wait_outcome(output int lat, output bit gv, output bit hit);
    lat = 0; gv = 1'b0; hit = 1'b0;
    while (lat < 200) begin
      tick();
      lat++;
      if (o_valid) begin gv = 1'b1; hit = 1'b1; break; end
      if (o_resync) begin hit = 1'b1; break; end
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   lat;
    bit   gv;
    bit   hit;
    lock = '0; deskew = 1'b0;
    tick(); tick();
    ids = v.ids; lock = '1;
    tick();
    check({v.name, "_wait_deskew_state"}, int'(o_state), 2);
    exp_q.push_back(v);
    deskew = 1'b1;
    tick();
    wait_outcome(lat, gv, hit);
    e = exp_q.pop_front();
    check({e.name, "_outcome_seen"}, int'(hit), 1);
    check({e.name, "_valid"}, int'(gv), int'(e.ok));
    check({e.name, "_latency"}, lat, e.ok ? 22 : 21);
    check({e.name, "_err_dup"}, int'(o_dup), int'(e.dup));
    check({e.name, "_err_range"}, int'(o_rng), int'(e.rng));
    if (e.ok) begin
      chk_sel({e.name, "_selector"}, o_sel, e.sel);
    end else begin
      check({e.name, "_resync"}, int'(o_resync), 1);
      tick();
      check({e.name, "_after_err_state"}, int'(o_state), 1);
      check({e.name, "_after_err_valid"}, int'(o_valid), 0);
      check({e.name, "_resync_pulse_len"}, int'(o_resync), 0);
    end
    $display("vec %s: latency=%0d valid=%0b dup=%0b range=%0b", e.name, lat, gv, o_dup, o_rng);
  endtask

  initial begin
    int                   lat;
    bit                   gv;
    bit                   hit;
    int                   k;
    logic [NB_ID_BUS-1:0] ident;
    logic [NB_ID_BUS-1:0] rev;
    logic [NB_ID_BUS-1:0] partial;

    ident = '0; rev = '0; partial = '0;
    for (int p = 0; p < N_LANES; p++) begin
      ident = putf(ident, p, p);
      rev   = putf(rev, p, N_LANES - 1 - p);
    end
    for (int p = 0; p < 10; p++) partial = putf(partial, N_LANES - 1 - p, p);

    vecs[0] = '{name: "identity", ids: ident, ok: 1'b1, sel: ident, dup: 1'b0, rng: 1'b0};
    vecs[1] = '{name: "reversed", ids: rev,   ok: 1'b1, sel: rev,   dup: 1'b0, rng: 1'b0};
    make_perm(vecs[2], "perm_a");
    vecs[3] = '{name: "dup", ids: '0, ok: 1'b0, sel: '0, dup: 1'b1, rng: 1'b0};
    k = 0;
    for (int p = 0; p < N_LANES; p++) begin
      if (p == 3 || p == 7) begin
        vecs[3].ids = putf(vecs[3].ids, p, 5);
      end else begin
        while (k == 5 || k == 9) k++;
        vecs[3].ids = putf(vecs[3].ids, p, k);
        k++;
      end
    end
    vecs[4] = '{name: "range", ids: putf(ident, 0, 25), ok: 1'b0, sel: '0, dup: 1'b0, rng: 1'b1};
    make_perm(vecs[5], "perm_b");

    rst_n = 1'b0; en = 1'b1; vld = 1'b1; lock = '0; deskew = 1'b0; ids = '0;
    tick(); tick();
    check("reset_state", int'(o_state), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_resync", int'(o_resync), 0);
    check("reset_err_dup", int'(o_dup), 0);
    check("reset_err_range", int'(o_rng), 0);
    chk_sel("reset_selector", o_sel, '0);
    rst_n = 1'b1;
    tick();
    check("idle_to_wait_lock", int'(o_state), 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Deskew never arrives: resync after DESKEW_TMO valid cycles.
    lock = '0; deskew = 1'b0;
    tick(); tick();
    lock = '1;
    tick();
    check("tmo_wait_deskew_state", int'(o_state), 2);
    lat = 0; hit = 1'b0;
    while (lat < 200) begin
      tick();
      lat++;
      if (o_resync) begin hit = 1'b1; break; end
    end
    check("tmo_resync_seen", int'(hit), 1);
    check("tmo_latency", lat, 64);
    check("tmo_error_state", int'(o_state), 6);
    lock = '0;
    $display("seq deskew_timeout: resync after %0d valid cycles", lat);

    // Lock drop while LOCKED, then relock with the same map.
    run_vec(vecs[0]);
    lock[4] = 1'b0;
    tick();
    check("drop_state", int'(o_state), 1);
    check("drop_no_resync", int'(o_resync), 0);
    tick();
    check("drop_valid_low", int'(o_valid), 0);
    lock = '1;
    wait_outcome(lat, gv, hit);
    check("relock_valid", int'(gv), 1);
    check("relock_latency", lat, 24);
    chk_sel("relock_selector", o_sel, ident);
    $display("seq lock_drop: relocked after %0d cycles", lat);

    // Disabled block freezes even though lock is gone.
    en = 1'b0; lock = '0;
    tick(); tick(); tick();
    check("freeze_state", int'(o_state), 5);
    check("freeze_valid", int'(o_valid), 1);
    en = 1'b1;
    tick();
    check("unfreeze_state", int'(o_state), 1);
    tick();
    check("unfreeze_valid", int'(o_valid), 0);
    $display("seq enable_freeze: done");

    // i_valid toggling during BUILD stretches the walk to 20 valid cycles.
    ids = ident; deskew = 1'b0; lock = '1;
    tick();
    deskew = 1'b1;
    tick();
    lat = 0; gv = 1'b0;
    while (lat < 100) begin
      vld = (lat % 2 == 0);
      tick();
      lat++;
      if (o_valid) begin gv = 1'b1; break; end
    end
    vld = 1'b1;
    check("toggle_valid", int'(gv), 1);
    check("toggle_latency", lat, 41);
    chk_sel("toggle_selector", o_sel, ident);
    $display("seq valid_toggle: valid after %0d cycles", lat);

    // Asynchronous reset in the middle of BUILD.
    lock = '0; deskew = 1'b0;
    tick(); tick();
    ids = rev; lock = '1;
    tick();
    deskew = 1'b1;
    tick();
    repeat (10) tick();
    chk_sel("midbuild_partial_selector", o_sel, partial);
    check("midbuild_state", int'(o_state), 3);
    rst_n = 1'b0;
    #1;
    check("async_reset_state", int'(o_state), 0);
    chk_sel("async_reset_selector", o_sel, '0);
    check("async_reset_valid", int'(o_valid), 0);
    tick();
    check("held_reset_state", int'(o_state), 0);
    $display("seq midbuild_reset: done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
